param_return_stack: RTL

PARAM_RETURN_STACK -- requirements
Module: param_return_stack

---
 rtl/param_return_stack.sv | 131 +++++++++++++
 1 files changed

// File: rtl/param_return_stack.sv
// LIFO return/parameter stack: circular buffer with top pointer and count,
// with the top two entries mirrored in registers so a and b are pure flops.
module param_return_stack #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 64,
    parameter int OVF_MODE = 0
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [1:0]                 stackOP,
    input  logic [WIDTH-1:0]           w,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           a,
    output logic [WIDTH-1:0]           b,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_PUSH = 2'd1,
        OP_REPL = 2'd2,
        OP_POP  = 2'd3
    } op_t;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    top_reg, top_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;

    logic             wr_en;
    logic [PW-1:0]    wr_addr;
    logic             ovf_evt, unf_evt;
    logic             is_empty, is_full;
    logic [WIDTH-1:0] third_entry;
    op_t              op;

    assign op          = op_t'(stackOP);
    assign is_empty    = (count_reg == '0);
    assign is_full     = (count_reg == CW'(DEPTH));
    // Entry below b; only consumed on a pop, addressed from registered state.
    assign third_entry = mem[top_reg - PW'(2)];

    always_comb begin
        top_next   = top_reg;
        count_next = count_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        wr_en      = 1'b0;
        wr_addr    = top_reg;
        ovf_evt    = 1'b0;
        unf_evt    = 1'b0;
        case (op)
            OP_PUSH: begin
                ovf_evt = is_full;
                if (!(is_full && OVF_MODE != 0)) begin
                    // When full, top+1 aliases the bottom slot, so the write drops it.
                    wr_en    = 1'b1;
                    wr_addr  = top_reg + PW'(1);
                    top_next = top_reg + PW'(1);
                    a_next   = w;
                    b_next   = a_reg;
                    if (!is_full)
                        count_next = count_reg + CW'(1);
                end
            end
            OP_REPL: begin
                wr_en  = 1'b1;
                a_next = w;
                if (is_empty)
                    count_next = CW'(1);
            end
            OP_POP: begin
                if (is_empty) begin
                    unf_evt = 1'b1;
                end else begin
                    top_next   = top_reg - PW'(1);
                    count_next = count_reg - CW'(1);
                    a_next     = b_reg;
                    b_next     = (count_reg >= CW'(3)) ? third_entry : '0;
                end
            end
            default: ;
        endcase
        // A new error event wins over a simultaneous clear.
        ovf_next = (ovf_reg & ~clr_err) | ovf_evt;
        unf_next = (unf_reg & ~clr_err) | unf_evt;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            top_reg   <= '0;
            count_reg <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            top_reg   <= top_next;
            count_reg <= count_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en && reset)
            mem[wr_addr] <= w;
    end

    assign a         = a_reg;
    assign b         = b_reg;
    assign count     = count_reg;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_reg;
    assign underflow = unf_reg;

endmodule
